// File: rtl/position_integrator.sv
// Position integrator: accumulates per-frame 12.4 fixed-point velocity into the
// character position, resolves floor landing / walk-off, blast-zone KO and the
// respawn countdown, and produces the is_grounded feedback for physics_engine.
module position_integrator #(
  parameter int FLOOR_Y        = 400,
  parameter int FLOOR_X0       = 120,
  parameter int FLOOR_X1       = 520,
  parameter int BLAST_L        = -64,
  parameter int BLAST_R        = 703,
  parameter int BLAST_T        = -128,
  parameter int BLAST_B        = 543,
  parameter int SPAWN_X        = 320,
  parameter int SPAWN_Y        = 100,
  parameter int RESPAWN_FRAMES = 90
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic signed [10:0] vel_x_in,
  input  logic signed [10:0] vel_y_in,
  output logic signed [11:0] pos_x,
  output logic signed [11:0] pos_y,
  output logic               is_grounded,
  output logic               active,
  output logic               land_pulse,
  output logic               ko_pulse,
  output logic               update_done
);

  localparam int unsigned FIX_W = 16;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned CNT_W = $clog2(RESPAWN_FRAMES + 1);

  // Stage geometry in whole pixels, at the width of the shifted position.
  localparam logic signed [FIX_W-1:0] FLOOR_Y_PIX  = FIX_W'(FLOOR_Y);
  localparam logic signed [FIX_W-1:0] FLOOR_X0_PIX = FIX_W'(FLOOR_X0);
  localparam logic signed [FIX_W-1:0] FLOOR_X1_PIX = FIX_W'(FLOOR_X1);
  localparam logic signed [FIX_W-1:0] BLAST_L_PIX  = FIX_W'(BLAST_L);
  localparam logic signed [FIX_W-1:0] BLAST_R_PIX  = FIX_W'(BLAST_R);
  localparam logic signed [FIX_W-1:0] BLAST_T_PIX  = FIX_W'(BLAST_T);
  localparam logic signed [FIX_W-1:0] BLAST_B_PIX  = FIX_W'(BLAST_B);

  // Fixed-point constants used when pinning or respawning.
  localparam logic signed [FIX_W-1:0] FLOOR_Y_FIX = FIX_W'(FLOOR_Y * 16);
  localparam logic signed [FIX_W-1:0] SPAWN_X_FIX = FIX_W'(SPAWN_X * 16);
  localparam logic signed [FIX_W-1:0] SPAWN_Y_FIX = FIX_W'(SPAWN_Y * 16);
  localparam logic [CNT_W-1:0]        RESPAWN_CNT = CNT_W'(RESPAWN_FRAMES);

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    RESOLVE,
    COMMIT,
    RESPAWN
  } state_t;

  state_t                   state;
  logic signed [FIX_W-1:0]  pos_x_fix;
  logic signed [FIX_W-1:0]  pos_y_fix;
  logic signed [FIX_W-1:0]  vy;
  logic signed [FIX_W-1:0]  nx;
  logic signed [FIX_W-1:0]  ny;
  logic [CNT_W-1:0]         respawn_cnt;

  logic signed [FIX_W-1:0]  nx_pix;
  logic signed [FIX_W-1:0]  ny_pix;
  logic signed [FIX_W-1:0]  py_pix;
  logic                     in_span;
  logic                     ko_hit;
  logic                     land_hit;

  // Signed add that clamps to the 16-bit range instead of wrapping.
  function automatic logic signed [FIX_W-1:0] sat_add(
    input logic signed [FIX_W-1:0] a,
    input logic signed [FIX_W-1:0] b
  );
    logic signed [FIX_W:0] s;
    s = (FIX_W+1)'(a) + (FIX_W+1)'(b);
    if (s[FIX_W] != s[FIX_W-1]) begin
      sat_add = s[FIX_W] ? 16'sh8000 : 16'sh7fff;
    end else begin
      sat_add = s[FIX_W-1:0];
    end
  endfunction

  // Whole-pixel outputs are the integer part of the fixed-point registers.
  assign pos_x = pos_x_fix[FIX_W-1:FRAC_W];
  assign pos_y = pos_y_fix[FIX_W-1:FRAC_W];

  // Collision tests on the candidate position held from SUM.
  always_comb begin
    nx_pix   = nx >>> FRAC_W;
    ny_pix   = ny >>> FRAC_W;
    py_pix   = pos_y_fix >>> FRAC_W;
    in_span  = (nx_pix >= FLOOR_X0_PIX) && (nx_pix <= FLOOR_X1_PIX);
    ko_hit   = (nx_pix < BLAST_L_PIX) || (nx_pix > BLAST_R_PIX) ||
               (ny_pix < BLAST_T_PIX) || (ny_pix > BLAST_B_PIX);
    land_hit = !is_grounded && (vy > 16'sd0) && (py_pix <= FLOOR_Y_PIX) &&
               (ny_pix >= FLOOR_Y_PIX) && in_span;
  end

  // Frame update sequencer with registered position, flags and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pos_x_fix   <= SPAWN_X_FIX;
      pos_y_fix   <= SPAWN_Y_FIX;
      vy          <= '0;
      nx          <= '0;
      ny          <= '0;
      respawn_cnt <= '0;
      is_grounded <= 1'b0;
      active      <= 1'b1;
      land_pulse  <= 1'b0;
      ko_pulse    <= 1'b0;
      update_done <= 1'b0;
    end else begin
      land_pulse  <= 1'b0;
      ko_pulse    <= 1'b0;
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) state <= SUM;
        end
        SUM: begin
          vy    <= FIX_W'(vel_y_in);
          nx    <= sat_add(pos_x_fix, FIX_W'(vel_x_in));
          ny    <= sat_add(pos_y_fix, FIX_W'(vel_y_in));
          state <= RESOLVE;
        end
        RESOLVE: begin
          update_done <= 1'b1;
          state       <= COMMIT;
          if (ko_hit) begin
            ko_pulse    <= 1'b1;
            pos_x_fix   <= SPAWN_X_FIX;
            pos_y_fix   <= SPAWN_Y_FIX;
            is_grounded <= 1'b0;
            active      <= 1'b0;
            respawn_cnt <= RESPAWN_CNT;
          end else if (land_hit) begin
            land_pulse  <= 1'b1;
            pos_x_fix   <= nx;
            pos_y_fix   <= FLOOR_Y_FIX;
            is_grounded <= 1'b1;
          end else if (is_grounded && (vy < 16'sd0)) begin
            pos_x_fix   <= nx;
            pos_y_fix   <= ny;
            is_grounded <= 1'b0;
          end else if (is_grounded) begin
            pos_x_fix   <= nx;
            pos_y_fix   <= FLOOR_Y_FIX;
            if (!in_span) is_grounded <= 1'b0;
          end else begin
            pos_x_fix   <= nx;
            pos_y_fix   <= ny;
          end
        end
        COMMIT: begin
          state <= ko_pulse ? RESPAWN : IDLE;
        end
        RESPAWN: begin
          if (frame_tick) begin
            respawn_cnt <= respawn_cnt - CNT_W'(1);
            if (respawn_cnt == CNT_W'(1)) begin
              active <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_position_integrator.sv
// Bench for position_integrator: reference model pushes expected frame results,
// a negedge monitor pops them on every update_done.
module tb_position_integrator;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_tick = 1'b0;
  logic signed [10:0] vel_x_in = '0;
  logic signed [10:0] vel_y_in = '0;
  logic signed [11:0] pos_x;
  logic signed [11:0] pos_y;
  logic               is_grounded;
  logic               active;
  logic               land_pulse;
  logic               ko_pulse;
  logic               update_done;

  int errors = 0;
  int checks = 0;
  int n_upd  = 0;
  int n_land = 0;
  int n_ko   = 0;

  typedef struct {
    int x;
    int y;
    bit g;
    bit land;
    bit ko;
    bit act;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state (fixed-point 12.4)
  int m_px, m_py, m_cnt;
  bit m_g, m_act;

  position_integrator dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
    .pos_x(pos_x), .pos_y(pos_y), .is_grounded(is_grounded), .active(active),
    .land_pulse(land_pulse), .ko_pulse(ko_pulse), .update_done(update_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: each update_done must match the oldest expected result.
  always @(negedge clk) begin
    if (update_done === 1'b1) begin
      exp_t e;
      n_upd  = n_upd + 1;
      n_land = n_land + int'(land_pulse);
      n_ko   = n_ko + int'(ko_pulse);
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_update: got update_done with no frame pending");
      end else begin
        e = exp_q.pop_front();
        if (int'(pos_x) !== e.x || int'(pos_y) !== e.y || is_grounded !== e.g ||
            land_pulse !== e.land || ko_pulse !== e.ko || active !== e.act) begin
          errors = errors + 1;
          $display("FAIL frame_result: got pos=(%0d,%0d) g=%b land=%b ko=%b act=%b, need pos=(%0d,%0d) g=%b land=%b ko=%b act=%b",
                   pos_x, pos_y, is_grounded, land_pulse, ko_pulse, active,
                   e.x, e.y, e.g, e.land, e.ko, e.act);
        end
      end
    end
  end

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    m_px = 320 * 16; m_py = 100 * 16; m_g = 0; m_act = 1; m_cnt = 0;
    exp_q.delete();
  endtask

  // One frame of the reference model; pushes an expectation unless respawning.
  task automatic model_tick(input int vx, input int vy);
    int nx, ny, nxp, nyp, pyp;
    bit land, ko;
    exp_t e;
    if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_act = 1;
      return;
    end
    nx = sat16(m_px + vx); ny = sat16(m_py + vy);
    nxp = nx >>> 4; nyp = ny >>> 4; pyp = m_py >>> 4;
    land = 0; ko = 0;
    if (nxp < -64 || nxp > 703 || nyp < -128 || nyp > 543) begin
      ko = 1; m_px = 320 * 16; m_py = 100 * 16; m_g = 0; m_act = 0; m_cnt = 90;
    end else if (!m_g && vy > 0 && pyp <= 400 && nyp >= 400 && nxp >= 120 && nxp <= 520) begin
      land = 1; m_px = nx; m_py = 400 * 16; m_g = 1;
    end else if (m_g && vy < 0) begin
      m_px = nx; m_py = ny; m_g = 0;
    end else if (m_g) begin
      m_px = nx; m_py = 400 * 16;
      if (nxp < 120 || nxp > 520) m_g = 0;
    end else begin
      m_px = nx; m_py = ny;
    end
    e.x = m_px >>> 4; e.y = m_py >>> 4; e.g = m_g; e.land = land; e.ko = ko; e.act = m_act;
    exp_q.push_back(e);
  endtask

  // One-cycle frame_tick, then enough cycles for the update to complete.
  task automatic send_tick(input int vx, input int vy);
    @(posedge clk); #1;
    vel_x_in = 11'(vx); vel_y_in = 11'(vy); frame_tick = 1'b1;
    model_tick(vx, vy);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL update_timeout: %0d frame results still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks = checks + 1;
    if (pos_x !== 12'sd320 || pos_y !== 12'sd100 || is_grounded !== 1'b0 || active !== 1'b1 ||
        land_pulse !== 1'b0 || ko_pulse !== 1'b0 || update_done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_state: got pos=(%0d,%0d) g=%b act=%b pulses=%b%b%b, need (320,100) g=0 act=1 pulses=000",
               pos_x, pos_y, is_grounded, active, land_pulse, ko_pulse, update_done);
    end
  endtask

  task automatic test_latency();
    logic [3:0] ud;
    @(posedge clk); #1;
    vel_x_in = 11'sd16; vel_y_in = 11'sd0; frame_tick = 1'b1;
    model_tick(16, 0);
    @(negedge clk); ud[0] = update_done;
    @(posedge clk); #1; frame_tick = 1'b0;
    @(negedge clk); ud[1] = update_done;
    @(negedge clk); ud[2] = update_done;
    @(negedge clk); ud[3] = update_done;
    checks = checks + 1;
    if (ud !== 4'b1000) begin
      errors = errors + 1;
      $display("FAIL latency: update_done per cycle (3..0)=%b, need 1000", ud);
    end
    repeat (2) @(posedge clk);
    #1;
    checks = checks + 1;
    if (pos_x !== 12'sd321 || pos_y !== 12'sd100 || is_grounded !== 1'b0 || active !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL first_step: got pos=(%0d,%0d) g=%b act=%b, need (321,100) g=0 act=1",
               pos_x, pos_y, is_grounded, active);
    end
  endtask

  task automatic test_landing();
    int l0;
    do_reset();
    for (int i = 0; i < 54; i++) send_tick(0, 88);
    checks = checks + 1;
    if (pos_y !== 12'sd397 || is_grounded !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL pre_land: got y=%0d g=%b, need y=397 g=0", pos_y, is_grounded);
    end
    l0 = n_land;
    send_tick(0, 88);
    checks = checks + 1;
    if (pos_y !== 12'sd400 || is_grounded !== 1'b1 || n_land != l0 + 1) begin
      errors = errors + 1;
      $display("FAIL land: got y=%0d g=%b lands=%0d, need y=400 g=1 lands=1", pos_y, is_grounded, n_land - l0);
    end
    send_tick(0, 88);
    checks = checks + 1;
    if (pos_y !== 12'sd400 || is_grounded !== 1'b1 || n_land != l0 + 1) begin
      errors = errors + 1;
      $display("FAIL pinned: got y=%0d g=%b lands=%0d, need y=400 g=1 lands=1", pos_y, is_grounded, n_land - l0);
    end
  endtask

  // Continues from the grounded state left by test_landing.
  task automatic test_walk_off();
    for (int i = 0; i < 66; i++) send_tick(48, 0);
    checks = checks + 1;
    if (pos_x !== 12'sd518 || is_grounded !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL edge_walk: got x=%0d g=%b, need x=518 g=1", pos_x, is_grounded);
    end
    send_tick(48, 0);
    checks = checks + 1;
    if (pos_x !== 12'sd521 || pos_y !== 12'sd400 || is_grounded !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL walk_off: got pos=(%0d,%0d) g=%b, need (521,400) g=0", pos_x, pos_y, is_grounded);
    end
    send_tick(48, 16);
    checks = checks + 1;
    if (pos_x !== 12'sd524 || pos_y !== 12'sd401 || is_grounded !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL fall_free: got pos=(%0d,%0d) g=%b, need (524,401) g=0", pos_x, pos_y, is_grounded);
    end
  endtask

  task automatic test_jump();
    do_reset();
    for (int i = 0; i < 55; i++) send_tick(0, 88);
    send_tick(0, -100);
    checks = checks + 1;
    if (pos_y !== 12'sd393 || is_grounded !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL jump: got y=%0d g=%b, need y=393 g=0", pos_y, is_grounded);
    end
  endtask

  task automatic test_ko_respawn();
    int k0, u0;
    do_reset();
    for (int i = 0; i < 5; i++) send_tick(1023, 0);
    checks = checks + 1;
    if (pos_x !== 12'sd639 || active !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL ko_approach: got x=%0d act=%b, need x=639 act=1", pos_x, active);
    end
    k0 = n_ko;
    send_tick(1023, 0);
    checks = checks + 1;
    if (pos_x !== 12'sd703 || n_ko != k0 || active !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL ko_boundary: got x=%0d kos=%0d act=%b, need x=703 kos=0 act=1", pos_x, n_ko - k0, active);
    end
    send_tick(1023, 0);
    checks = checks + 1;
    if (pos_x !== 12'sd320 || pos_y !== 12'sd100 || n_ko != k0 + 1 || active !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL ko: got pos=(%0d,%0d) kos=%0d act=%b, need (320,100) kos=1 act=0",
               pos_x, pos_y, n_ko - k0, active);
    end
    u0 = n_upd;
    for (int i = 0; i < 89; i++) send_tick(int'($urandom_range(0, 2000)) - 1000, 50);
    checks = checks + 1;
    if (active !== 1'b0 || n_upd != u0 || pos_x !== 12'sd320 || pos_y !== 12'sd100) begin
      errors = errors + 1;
      $display("FAIL respawn_hold: got act=%b updates=%0d pos=(%0d,%0d), need act=0 updates=0 (320,100)",
               active, n_upd - u0, pos_x, pos_y);
    end
    send_tick(500, 500);
    checks = checks + 1;
    if (active !== 1'b1 || n_upd != u0) begin
      errors = errors + 1;
      $display("FAIL respawn_exit: got act=%b updates=%0d, need act=1 updates=0", active, n_upd - u0);
    end
    send_tick(16, 0);
    checks = checks + 1;
    if (pos_x !== 12'sd321 || n_upd != u0 + 1) begin
      errors = errors + 1;
      $display("FAIL resume: got x=%0d updates=%0d, need x=321 updates=1", pos_x, n_upd - u0);
    end
  endtask

  task automatic test_back_to_back();
    int u0;
    do_reset();
    u0 = n_upd;
    @(posedge clk); #1;
    vel_x_in = 11'sd32; vel_y_in = 11'sd0; frame_tick = 1'b1;
    model_tick(32, 0);
    repeat (2) @(posedge clk);
    #1;
    frame_tick = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks = checks + 1;
    if (n_upd != u0 + 1 || pos_x !== 12'sd322) begin
      errors = errors + 1;
      $display("FAIL back_to_back: got updates=%0d x=%0d, need updates=1 x=322", n_upd - u0, pos_x);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_respawn();
    do_reset();
    for (int i = 0; i < 7; i++) send_tick(1023, 0);
    for (int i = 0; i < 50; i++) send_tick(0, 0);
    checks = checks + 1;
    if (active !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mid_respawn: got act=%b, need act=0", active);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    checks = checks + 1;
    if (active !== 1'b1 || pos_x !== 12'sd320 || pos_y !== 12'sd100 || is_grounded !== 1'b0 ||
        land_pulse !== 1'b0 || ko_pulse !== 1'b0 || update_done !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_in_respawn: got act=%b pos=(%0d,%0d) g=%b pulses=%b%b%b, need act=1 (320,100) g=0 pulses=000",
               active, pos_x, pos_y, is_grounded, land_pulse, ko_pulse, update_done);
    end
    send_tick(16, 0);
    checks = checks + 1;
    if (pos_x !== 12'sd321) begin
      errors = errors + 1;
      $display("FAIL post_reset_idle: got x=%0d, need x=321", pos_x);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_landing();
    test_walk_off();
    test_jump();
    test_ko_respawn();
    test_back_to_back();
    test_reset_mid_respawn();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
